// File: rtl/q6_24_str_pkg.sv
// Shared constants for the six-state Johnson sequence counter.
package q6_24_str_pkg;
    localparam int CNT_W = 3;
endpackage

// File: rtl/q6_24_str_jk_ff.sv
// JK flip-flop with synchronous active-high reset; q updates one clock after j/k/rst are sampled.
// No handshake: the flop updates on every rising edge.
module jk_ff (
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                2'b11:   q <= ~q;
                default: q <= q;
            endcase
        end
    end

    assign qn = ~q;

endmodule

// File: rtl/q6_24_str.sv
// Six-state Johnson counter (000,001,011,111,110,100) built from three JK flops; count moves one step per edge.
// Unused codes 010/101 fall to 000 on the next edge; rstb is synchronous and active-high.
module q6_24_str
    import q6_24_str_pkg::*;
(
    input  logic             clk,
    input  logic             rstb,
    output logic [CNT_W-1:0] count
);

    logic q0, q1, q2;
    logic n0, n1, n2;
    logic j0, k0, j1, k1, j2, k2;

    and g_j0 (j0, n2, n1);
    // K0 reduces to Q2: from 111 the low bit must clear, and from 101 it must fall to 000.
    assign k0 = q2;

    and g_j1 (j1, q0, n2);
    assign k1 = n0;

    and g_j2 (j2, q1, q0);
    assign k2 = n1;

    jk_ff u_ff0 (.clk(clk), .rst(rstb), .j(j0), .k(k0), .q(q0), .qn(n0));
    jk_ff u_ff1 (.clk(clk), .rst(rstb), .j(j1), .k(k1), .q(q1), .qn(n1));
    jk_ff u_ff2 (.clk(clk), .rst(rstb), .j(j2), .k(k2), .q(q2), .qn(n2));

    assign count = {q2, q1, q0};

endmodule

// File: tb/tb_q6_24_str.sv
// Self-checking bench for q6_24_str: directed scenarios plus a random-reset scoreboard against a sequence-table model.
module tb_q6_24_str;

    logic       clk  = 1'b0;
    logic       rstb = 1'b1;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S0 = 3'b000;
    localparam logic [2:0] S1 = 3'b001;
    localparam logic [2:0] S2 = 3'b011;
    localparam logic [2:0] S3 = 3'b111;
    localparam logic [2:0] S4 = 3'b110;
    localparam logic [2:0] S5 = 3'b100;

    logic [2:0] seq_tbl [6];

    q6_24_str dut (
        .clk  (clk),
        .rstb (rstb),
        .count(count)
    );

    always #5 clk = ~clk;

    // Reference: reset wins; legal codes advance around the table; anything else goes to S0.
    function automatic logic [2:0] ref_next(input logic [2:0] s, input logic r);
        if (r) return S0;
        for (int i = 0; i < 6; i++) begin
            if (seq_tbl[i] == s) return seq_tbl[(i + 1) % 6];
        end
        return S0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstb = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (count !== S0) begin
                failures++;
                $display("FAIL reset edge %0d: count=%b expected=%b", i, count, S0);
            end
        end
    endtask

    task automatic test_full_cycle();
        logic [2:0] exp_s;
        exp_s = S0;
        rstb  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            exp_s = ref_next(exp_s, 1'b0);
            tick();
            checks++;
            if (count !== exp_s) begin
                failures++;
                $display("FAIL full_cycle step %0d: count=%b expected=%b", i, count, exp_s);
            end
        end
    endtask

    task automatic test_mid_reset();
        int budget;
        rstb   = 1'b0;
        budget = 0;
        while (count !== S3 && budget < 8) begin
            tick();
            budget++;
        end
        checks++;
        if (count !== S3) begin
            failures++;
            $display("FAIL mid_reset reach_111: count=%b expected=%b within 8 edges", count, S3);
        end
        rstb = 1'b1;
        tick();
        checks++;
        if (count !== S0) begin
            failures++;
            $display("FAIL mid_reset assert: count=%b expected=%b", count, S0);
        end
        rstb = 1'b0;
        tick();
        checks++;
        if (count !== S1) begin
            failures++;
            $display("FAIL mid_reset resume: count=%b expected=%b", count, S1);
        end
    endtask

    task automatic deposit_and_check(input logic [2:0] v);
        logic [2:0] exp_s;
        rstb = 1'b0;
        @(negedge clk);
        force dut.u_ff2.q = v[2];
        force dut.u_ff1.q = v[1];
        force dut.u_ff0.q = v[0];
        #1;
        release dut.u_ff2.q;
        release dut.u_ff1.q;
        release dut.u_ff0.q;
        #1;
        checks++;
        if (count !== v) begin
            failures++;
            $display("FAIL illegal deposit %b: count=%b expected=%b", v, count, v);
        end
        exp_s = ref_next(v, 1'b0);
        tick();
        checks++;
        if (count !== exp_s) begin
            failures++;
            $display("FAIL illegal recover from %b: count=%b expected=%b", v, count, exp_s);
        end
    endtask

    task automatic test_illegal();
        deposit_and_check(3'b010);
        deposit_and_check(3'b101);
    endtask

    task automatic test_hold_reset();
        rstb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (count !== S0) begin
                failures++;
                $display("FAIL hold_reset edge %0d: count=%b expected=%b", i, count, S0);
            end
        end
        rstb = 1'b0;
        tick();
        checks++;
        if (count !== S1) begin
            failures++;
            $display("FAIL hold_reset release: count=%b expected=%b", count, S1);
        end
    endtask

    task automatic test_random();
        logic [2:0] m;
        m = S1;
        for (int i = 0; i < 50; i++) begin
            rstb = ($urandom_range(0, 4) == 0);
            m    = ref_next(m, rstb);
            tick();
            checks++;
            if (count !== m) begin
                failures++;
                $display("FAIL random edge %0d rstb=%b: count=%b expected=%b", i, rstb, count, m);
            end
        end
        rstb = 1'b0;
    endtask

    initial begin
        seq_tbl[0] = S0;
        seq_tbl[1] = S1;
        seq_tbl[2] = S2;
        seq_tbl[3] = S3;
        seq_tbl[4] = S4;
        seq_tbl[5] = S5;
        #2;
        test_reset();
        test_full_cycle();
        test_mid_reset();
        test_illegal();
        test_hold_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end

endmodule
